// File: rtl/sopc_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sopc_mem_arbiter_pkg
//  Purpose  : Shared types, defaults and the grant-selection helper for the
//             single-port memory arbiter of openmips_min_sopc.
//  Contents : arb_state_e  - 2-bit FSM state encoding
//             arb_gnt_e    - grant identifier (instruction / data port)
//             pick_grant() - priority selection with starvation override
//  Revision : 1.0  initial release
// ============================================================================
package sopc_mem_arbiter_pkg;

    // Default configuration.
    localparam int unsigned DEF_MEM_LAT    = 1;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Starvation counter must hold STARVE_MAX up to 15.
    localparam int unsigned STARVE_W = 4;
    // Latency counter counts 0..MEM_LAT-1 with MEM_LAT up to 4.
    localparam int unsigned LAT_W    = 3;

    // Fetches always access a full word.
    localparam logic [3:0] SEL_FETCH = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } arb_gnt_e;

    // Data wins unless the fetch port is also waiting and has already been
    // passed over the maximum number of times.
    function automatic arb_gnt_e pick_grant(
        input logic if_req,
        input logic dm_req,
        input logic starved
    );
        if (dm_req && !(if_req && starved)) begin
            return GNT_DATA;
        end
        return GNT_INST;
    endfunction

endpackage : sopc_mem_arbiter_pkg
`default_nettype wire

// File: rtl/sopc_mem_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sopc_mem_arbiter_starve_cnt
//  Purpose  : Saturating counter tracking consecutive data grants issued while
//             a fetch request is waiting.
//  Ports    : clk       in   system clock
//             rst_n     in   asynchronous reset, active-low
//             inc_i     in   count one passed-over fetch (saturates at MAX)
//             clr_i     in   clear to zero (wins over inc_i)
//             at_max_o  out  counter equals MAX
//  Revision : 1.0  initial release
// ============================================================================
module sopc_mem_arbiter_starve_cnt
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX   = DEF_STARVE_MAX,
    parameter int unsigned CNT_W = STARVE_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == C_MAX);

endmodule : sopc_mem_arbiter_starve_cnt
`default_nettype wire

// File: rtl/sopc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sopc_mem_arbiter
//  Purpose  : Shares one single-port synchronous memory between the CPU
//             instruction-fetch port and data port. Each request becomes one
//             fixed-latency memory access: IDLE -> ISSUE -> WAIT -> ACK.
//             Data has priority; a starvation bound guarantees fetch progress.
//  Ports    : clk, rst_n            clock, asynchronous active-low reset
//             if_req_i/if_addr_i    fetch request and address (held until ack)
//             if_ack_o/if_rdata_o   fetch completion pulse, registered word
//             dm_req_i/dm_we_i/dm_sel_i/dm_addr_i/dm_wdata_i
//                                   data request fields (held until ack)
//             dm_ack_o/dm_rdata_o   data completion pulse, registered word
//             mem_ce_o/mem_we_o/mem_sel_o/mem_addr_o/mem_wdata_o
//                                   memory strobe and fields (zero when idle)
//             mem_rdata_i           memory read data, valid MEM_LAT after ce
//             stallreq_o            pipeline stall while a request is pending
//  Revision : 1.0  initial release
// ============================================================================
module sopc_mem_arbiter
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,     // 1..4
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX   // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    // data port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    // memory port
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // pipeline control
    output logic              stallreq_o
);

    // Last WAIT cycle: the memory word is valid during it.
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    arb_state_e        state_q,    state_d;
    arb_gnt_e          gnt_q,      gnt_d;
    logic              we_q,       we_d;
    logic [3:0]        sel_q,      sel_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [LAT_W-1:0]  lat_q,      lat_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic     starve_inc;
    logic     starve_clr;
    logic     starve_at_max;
    arb_gnt_e pick;

    sopc_mem_arbiter_starve_cnt #(
        .MAX   (STARVE_MAX),
        .CNT_W (STARVE_W)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .at_max_o (starve_at_max)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        pick       = pick_grant(if_req_i, dm_req_i, starve_at_max);

        unique case (state_q)
            ST_IDLE: begin
                // No fetch waiting: nothing is being starved.
                if (!if_req_i) begin
                    starve_clr = 1'b1;
                end
                if (if_req_i || dm_req_i) begin
                    gnt_d   = pick;
                    state_d = ST_ISSUE;
                    if (pick == GNT_DATA) begin
                        we_d       = dm_we_i;
                        sel_d      = dm_sel_i;
                        addr_d     = dm_addr_i;
                        wdata_d    = dm_wdata_i;
                        starve_inc = if_req_i;
                    end else begin
                        we_d       = 1'b0;
                        sel_d      = SEL_FETCH;
                        addr_d     = if_addr_i;
                        wdata_d    = '0;
                        starve_clr = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                lat_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_ACK;
                    if (!we_q) begin
                        if (gnt_q == GNT_INST) begin
                            if_rdata_d = mem_rdata_i;
                        end else begin
                            dm_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end

            // The acked requester still shows req here, so no arbitration.
            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_INST;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: memory fields are gated so the bus is all-zero when idle.
    // ------------------------------------------------------------------
    assign mem_ce_o    = (state_q == ST_ISSUE);
    assign mem_we_o    = mem_ce_o & we_q;
    assign mem_sel_o   = mem_ce_o ? sel_q   : '0;
    assign mem_addr_o  = mem_ce_o ? addr_q  : '0;
    assign mem_wdata_o = mem_ce_o ? wdata_q : '0;

    assign if_ack_o    = (state_q == ST_ACK) && (gnt_q == GNT_INST);
    assign dm_ack_o    = (state_q == ST_ACK) && (gnt_q == GNT_DATA);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    assign stallreq_o  = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule : sopc_mem_arbiter
`default_nettype wire
